// File: rtl/pipe_pkg.sv
// Shared encodings and the registered ID/EX field bundle for the pipeline stage.
package pipe_pkg;

    localparam logic [4:0] REG_ZR   = 5'd31;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_STUR = 2'b01;
    localparam logic [1:0] FWD_I    = 2'b10;
    localparam logic [1:0] FWD_R    = 2'b11;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] target;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] fwd_en;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare between the load sitting in EX and the instruction in ID.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_target,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rn,
    input  logic [4:0] i_id_rm,
    input  logic [1:0] i_id_fwd_en,
    output logic       o_hazard
);

    logic w_ex_load;
    logic w_rn_hit;
    logic w_rm_hit;

    // STUR's Rt rides on the target field, so it is never compared here.
    assign w_ex_load = i_ex_valid && i_ex_mem_read && (i_ex_target != REG_ZR);
    assign w_rn_hit  = (i_id_fwd_en != FWD_NONE) && (i_id_rn == i_ex_target);
    assign w_rm_hit  = (i_id_fwd_en == FWD_R) && (i_id_rm == i_ex_target);
    assign o_hazard  = w_ex_load && i_id_valid && (w_rn_hit || w_rm_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W          = 8,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ID,
    input  logic [4:0]        Rn_ID,
    input  logic [4:0]        Rm_ID,
    input  logic [4:0]        targetReg_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic              MemWrite_ID,
    input  logic [1:0]        fwdEn_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic              flush,
    input  logic              hold,
    output logic              valid_EX,
    output logic [4:0]        Rn_EX,
    output logic [4:0]        Rm_EX,
    output logic [4:0]        targetReg_EX,
    output logic              RegWrite_EX,
    output logic              MemRead_EX,
    output logic              MemWrite_EX,
    output logic [1:0]        fwdEn_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_count,
    output hz_state_t         dbg_state
);

    localparam logic [1:0] REM_INIT = 2'(LOAD_USE_STALLS - 1);

    id_ex_t            r_ex;
    logic [CTRL_W-1:0] r_ctrl;
    hz_state_t         r_state;
    logic [1:0]        r_rem;
    logic [CNT_W-1:0]  r_bcnt;
    id_ex_t            w_id;
    logic              w_hazard;

    assign w_id = '{valid: valid_ID, rn: Rn_ID, rm: Rm_ID, target: targetReg_ID,
                    reg_write: RegWrite_ID, mem_read: MemRead_ID,
                    mem_write: MemWrite_ID, fwd_en: fwdEn_ID};

    load_use_detect u_detect (
        .i_ex_valid    (r_ex.valid),
        .i_ex_mem_read (r_ex.mem_read),
        .i_ex_target   (r_ex.target),
        .i_id_valid    (valid_ID),
        .i_id_rn       (Rn_ID),
        .i_id_rm       (Rm_ID),
        .i_id_fwd_en   (fwdEn_ID),
        .o_hazard      (w_hazard)
    );

    // Flush and hold both override the stall so the front end can redirect or freeze.
    assign stall = !reset && !flush && !hold && ((r_state == BUBBLE) || w_hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex    <= '0;
            r_ctrl  <= '0;
            r_state <= RUN;
            r_rem   <= 2'd0;
            r_bcnt  <= '0;
        end else if (flush) begin
            r_ex    <= '0;
            r_ctrl  <= '0;
            r_state <= RUN;
            r_rem   <= 2'd0;
        end else if (hold) begin
            r_ex    <= r_ex;
        end else if ((r_state == BUBBLE) || w_hazard) begin
            r_ex   <= '0;
            r_ctrl <= '0;
            if (r_bcnt != '1) begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            if (r_state == BUBBLE) begin
                r_rem <= r_rem - 2'd1;
                if (r_rem == 2'd1) begin
                    r_state <= RUN;
                end
            end else begin
                r_rem   <= REM_INIT;
                r_state <= (REM_INIT != 2'd0) ? BUBBLE : RUN;
            end
        end else begin
            r_ex   <= w_id;
            r_ctrl <= ctrl_ID;
        end
    end

    assign valid_EX     = r_ex.valid;
    assign Rn_EX        = r_ex.rn;
    assign Rm_EX        = r_ex.rm;
    assign targetReg_EX = r_ex.target;
    assign RegWrite_EX  = r_ex.reg_write;
    assign MemRead_EX   = r_ex.mem_read;
    assign MemWrite_EX  = r_ex.mem_write;
    assign fwdEn_EX     = r_ex.fwd_en;
    assign ctrl_EX      = r_ctrl;
    assign bubble_count = r_bcnt;
    assign dbg_state    = r_state;

endmodule
